// File: rtl/acc_drain_tx.sv
// acc_drain_tx
//   Captures a result tile (one accumulator row per accepted load beat) and
//   drains it as per-column 16-beat frames into the data buffer's
//   accumulate-write port. Column frames are skewed by one cycle each. Valid
//   rows occupy the tail of each frame; the leading `skip` beats are padding
//   that the buffer's back_count window discards.
//
// Ports
//   clk, rst         clock, synchronous active-high reset
//   start            one-cycle tile request (honoured only when idle)
//   gemm_size        tile row count 1..FRAME_LEN, sampled on accepted start
//   cnn_size         leading-row offset, sampled on accepted start
//   load_valid       accumulator row present on load_data
//   load_data        one tile row, column c at [c*DATA_W +: DATA_W]
//   load_ready       row accepted this cycle (LOAD)
//   act_sig          per-column frame strobe
//   data_out         per-column beat data
//   frame_done       pulse with the last beat of the last column
//   busy             high while a tile is loading or draining
//   cfg_err          pulse when start carries an illegal configuration
//
// Build option
//   ACC_DRAIN_ZERO_PAD_EN  when defined, padding beats drive zero; otherwise
//                          they drive the unmasked tile row k (cheaper, and
//                          the buffer discards those beats anyway).

module acc_drain_tx #(
  parameter int N_COL     = 16,
  parameter int DATA_W    = 20,
  parameter int FRAME_LEN = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [4:0]              gemm_size,
  input  logic [4:0]              cnn_size,
  input  logic                    load_valid,
  input  logic [N_COL*DATA_W-1:0] load_data,
  output logic                    load_ready,
  output logic [N_COL-1:0]        act_sig,
  output logic [N_COL*DATA_W-1:0] data_out,
  output logic                    frame_done,
  output logic                    busy,
  output logic                    cfg_err
);

  // Drain counter must hold 0..N_COL+FRAME_LEN-2 and be wide enough that
  // d - c wraps to a value >= FRAME_LEN whenever d < c.
  localparam int DW = $clog2(N_COL + FRAME_LEN);
  localparam int RW = $clog2(FRAME_LEN);
  localparam logic [DW-1:0] D_LAST = DW'(N_COL + FRAME_LEN - 2);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [DW-1:0] d_q, d_d;
  logic [4:0]    row_q, row_d;
  logic [4:0]    rows_q, rows_d;
  logic [4:0]    skip_q, skip_d;
  logic          busy_q, busy_d;
  logic          ready_q, ready_d;
  logic          cfg_err_q, cfg_err_d;
  logic          fd_q, fd_d;

  logic [N_COL-1:0]        act_q, act_d;
  logic [N_COL*DATA_W-1:0] data_q, data_d;

  // Tile storage, row-major; contents are not reset.
  logic [FRAME_LEN-1:0][N_COL*DATA_W-1:0] tile_q;

  // ---------------------------------------------------------------------------
  // Configuration decode
  // ---------------------------------------------------------------------------
  logic [4:0] rows_w, skip_w;
  logic       cfg_ok, idle_free, start_acc, row_acc, last_row;

  assign rows_w = gemm_size - cnn_size;
  assign skip_w = 5'(FRAME_LEN) - rows_w;
  assign cfg_ok = (gemm_size != 5'd0) && (gemm_size <= 5'(FRAME_LEN))
                  && (cnn_size < gemm_size);

  // busy_q stays high for the cycle after DRAIN exits, so a start in that
  // cycle (the one carrying frame_done) is still refused.
  assign idle_free = (state_q == S_IDLE) && !busy_q;
  assign start_acc = start && idle_free && cfg_ok;
  assign row_acc   = (state_q == S_LOAD) && load_valid;
  assign last_row  = row_acc && (row_q == rows_q - 5'd1);

  // ---------------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    d_d     = '0;
    row_d   = row_q;
    rows_d  = rows_q;
    skip_d  = skip_q;
    case (state_q)
      S_IDLE: begin
        if (start_acc) begin
          state_d = S_LOAD;
          row_d   = 5'd0;
          rows_d  = rows_w;
          skip_d  = skip_w;
        end
      end
      S_LOAD: begin
        if (row_acc) begin
          row_d = row_q + 5'd1;
          if (last_row) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (d_q == D_LAST) state_d = S_IDLE;
        else               d_d     = d_q + 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy_d    = (state_d != S_IDLE) || (state_q == S_DRAIN);
  assign ready_d   = (state_d == S_LOAD);
  assign cfg_err_d = start && idle_free && !cfg_ok;
  assign fd_d      = (state_q == S_DRAIN) && (d_q == D_LAST);

  // ---------------------------------------------------------------------------
  // Per-column beat generation
  //   beat index k = d - c; column active while k < FRAME_LEN (d < c wraps
  //   large). Beats k >= skip carry tile[k-skip][c].
  // ---------------------------------------------------------------------------
  logic drain_en;
  assign drain_en = (state_q == S_DRAIN);

  for (genvar c = 0; c < N_COL; c++) begin : g_col
    logic [DW-1:0]     kf;
    logic              active, pad;
    logic [RW-1:0]     idx;
    logic [DATA_W-1:0] sel;

    assign kf     = d_q - DW'(c);
    assign active = drain_en && (kf < DW'(FRAME_LEN));
    assign pad    = kf < DW'(skip_q);
    assign idx    = pad ? kf[RW-1:0] : RW'(kf - DW'(skip_q));
    assign sel    = tile_q[idx][c*DATA_W +: DATA_W];

    assign act_d[c] = active;
`ifdef ACC_DRAIN_ZERO_PAD_EN
    assign data_d[c*DATA_W +: DATA_W] = (active && !pad) ? sel : '0;
`else
    assign data_d[c*DATA_W +: DATA_W] = active ? sel : '0;
`endif
  end

  // ---------------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      d_q       <= '0;
      row_q     <= '0;
      rows_q    <= '0;
      skip_q    <= '0;
      busy_q    <= 1'b0;
      ready_q   <= 1'b0;
      cfg_err_q <= 1'b0;
      fd_q      <= 1'b0;
      act_q     <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      d_q       <= d_d;
      row_q     <= row_d;
      rows_q    <= rows_d;
      skip_q    <= skip_d;
      busy_q    <= busy_d;
      ready_q   <= ready_d;
      cfg_err_q <= cfg_err_d;
      fd_q      <= fd_d;
      act_q     <= act_d;
      data_q    <= data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (row_acc) tile_q[row_q[RW-1:0]] <= load_data;
  end

  assign load_ready = ready_q;
  assign act_sig    = act_q;
  assign data_out   = data_q;
  assign frame_done = fd_q;
  assign busy       = busy_q;
  assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_acc_drain_tx.sv
module tb_acc_drain_tx;
  localparam int N_COL  = 16;
  localparam int DATA_W = 20;
  localparam int FL     = 16;
  localparam int BW     = N_COL * DATA_W;
  localparam int CW     = 512;

  logic              clk = 1'b0;
  logic              rst, start, load_valid;
  logic [4:0]        gemm_size, cnn_size;
  logic [BW-1:0]     load_data, data_out;
  logic              load_ready, frame_done, busy, cfg_err;
  logic [N_COL-1:0]  act_sig;

  acc_drain_tx #(.N_COL(N_COL), .DATA_W(DATA_W), .FRAME_LEN(FL)) dut (
    .clk(clk), .rst(rst), .start(start), .gemm_size(gemm_size),
    .cnn_size(cnn_size), .load_valid(load_valid), .load_data(load_data),
    .load_ready(load_ready), .act_sig(act_sig), .data_out(data_out),
    .frame_done(frame_done), .busy(busy), .cfg_err(cfg_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference tile register: what the block should hold, row by row.
  logic [DATA_W-1:0] mtile [FL][N_COL];
  bit                known [FL];

  typedef struct {
    int g; int cn; bit err; int mode; int gap; bit sdd; int rst_at;
  } vec_t;

  task automatic chk(input string nm, input logic [CW-1:0] got,
                     input logic [CW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic logic [DATA_W-1:0] cellval(input int mode, input int r,
                                                input int c);
    case (mode)
      0:       return DATA_W'(r * 16 + c);
      1:       return DATA_W'((r + 1) * 'h11);
      default: return DATA_W'($urandom);
    endcase
  endfunction

  task automatic junk_row();
    for (int c = 0; c < N_COL; c++) load_data[c*DATA_W +: DATA_W] = DATA_W'($urandom);
  endtask

  task automatic bad_cfg(input int g, input int cn);
    start = 1'b1; gemm_size = 5'(g); cnn_size = 5'(cn);
    tick;
    start = 1'b0;
    chk("cfg_err_pulse", CW'(cfg_err), CW'(1));
    chk("busy_bad_cfg", CW'(busy), CW'(0));
    chk("act_bad_cfg", CW'(act_sig), CW'(0));
    tick;
    chk("cfg_err_once", CW'(cfg_err), CW'(0));
    chk("idle_bad_cfg", CW'({busy, load_ready, act_sig}), CW'(0));
  endtask

  // Load a tile, then follow the 32 drain cycles against the frame rules and
  // push the strobed beats through a back_count-style buffer model.
  task automatic run_tile(input int g, input int cn, input int mode,
                          input int gap, input bit sdd, input int rst_at);
    int rows, skip, r, cyc, k;
    bit v, okc;
    logic [DATA_W-1:0] bq [N_COL][$];
    int bc [N_COL];
    logic [BW-1:0] row, exp_d, mask;
    logic [N_COL-1:0] exp_a;

    rows = g - cn;
    skip = FL - rows;
    // start together with a stray row: only start may take effect
    start = 1'b1; gemm_size = 5'(g); cnn_size = 5'(cn);
    load_valid = 1'b1; junk_row();
    tick;
    start = 1'b0; load_valid = 1'b0;
    chk("busy_after_start", CW'(busy), CW'(1));
    chk("ready_after_start", CW'(load_ready), CW'(1));
    chk("cfg_err_legal", CW'(cfg_err), CW'(0));

    r = 0; cyc = 0;
    while (r < rows) begin
      case (gap)
        0:       v = 1'b1;
        1:       v = (cyc % 7) < 2;
        default: v = $urandom_range(0, 2) != 0;
      endcase
      cyc++;
      if (v) begin
        for (int c = 0; c < N_COL; c++) begin
          mtile[r][c] = cellval(mode, r, c);
          row[c*DATA_W +: DATA_W] = mtile[r][c];
        end
        known[r] = 1'b1;
        load_valid = 1'b1; load_data = row;
        r++;
      end else begin
        load_valid = 1'b0; junk_row();
      end
      tick;
      if (r < rows) chk("load_ready_hold", CW'(load_ready), CW'(1));
    end

    // now in D0
    load_valid = (gap == 1);
    junk_row();
    chk("d0_state", CW'({load_ready, busy, act_sig}), CW'({1'b0, 1'b1, 16'h0}));
    for (int c = 0; c < N_COL; c++) begin bc[c] = 0; bq[c].delete(); end

    for (int t = 1; t <= 32; t++) begin
      start = (sdd && t == 5);
      if (start) begin gemm_size = 5'd16; cnn_size = 5'd0; end
      if (rst_at > 0 && t == rst_at + 1) rst = 1'b1;
      tick;
      if (rst) begin
        chk("reset_mid_drain", CW'({load_ready, act_sig, data_out, frame_done, busy, cfg_err}), CW'(0));
        rst = 1'b0; start = 1'b0; load_valid = 1'b0;
        for (int i = 0; i < FL; i++) known[i] = 1'b0;
        return;
      end
      exp_a = '0; exp_d = '0; mask = '1;
      for (int c = 0; c < N_COL; c++) begin
        if (t >= c + 1 && t <= c + 16) begin
          k = t - 1 - c;
          exp_a[c] = 1'b1;
          if (k >= skip) exp_d[c*DATA_W +: DATA_W] = mtile[k-skip][c];
          else begin
`ifdef ACC_DRAIN_ZERO_PAD_EN
            exp_d[c*DATA_W +: DATA_W] = '0;
`else
            if (known[k]) exp_d[c*DATA_W +: DATA_W] = mtile[k][c];
            else          mask[c*DATA_W +: DATA_W] = '0;
`endif
          end
        end
      end
      chk("act_sig", CW'(act_sig), CW'(exp_a));
      chk("data_out", CW'(data_out & mask), CW'(exp_d & mask));
      chk("frame_done", CW'(frame_done), CW'(t == 31));
      chk("busy_drain", CW'(busy), CW'(t <= 31));
      chk("ready_drain", CW'(load_ready), CW'(0));
      for (int c = 0; c < N_COL; c++) begin
        if (act_sig[c]) begin
          if (bc[c] >= skip) bq[c].push_back(data_out[c*DATA_W +: DATA_W]);
          bc[c]++;
        end
      end
    end
    start = 1'b0; load_valid = 1'b0;
    tick;
    chk("idle_after_drain", CW'({busy, load_ready, act_sig, frame_done}), CW'(0));
    for (int c = 0; c < N_COL; c++) begin
      okc = (bq[c].size() == rows);
      if (okc) for (int i = 0; i < rows; i++) if (bq[c][i] !== mtile[i][c]) okc = 1'b0;
      chk("buffer_col", CW'(okc), CW'(1));
    end
  endtask

  vec_t tbl [11];

  initial begin
    tbl[0]  = '{16, 0,  1'b0, 0, 0, 1'b0, -1};  // full tile, skip 0
    tbl[1]  = '{4,  1,  1'b0, 1, 0, 1'b0, -1};  // partial, skip 13
    tbl[2]  = '{3,  3,  1'b1, 0, 0, 1'b0, -1};  // cnn == gemm
    tbl[3]  = '{0,  0,  1'b1, 0, 0, 1'b0, -1};  // zero rows
    tbl[4]  = '{20, 1,  1'b1, 0, 0, 1'b0, -1};  // gemm > 16
    tbl[5]  = '{4,  0,  1'b0, 2, 1, 1'b1, -1};  // gaps + start during drain
    tbl[6]  = '{16, 0,  1'b0, 2, 2, 1'b0, 10};  // reset at D0+10
    tbl[7]  = '{16, 0,  1'b0, 2, 0, 1'b0, -1};  // clean tile after reset
    tbl[8]  = '{1,  0,  1'b0, 2, 2, 1'b0, -1};  // single row, skip 15
    tbl[9]  = '{16, 15, 1'b0, 2, 0, 1'b0, -1};  // max offset
    tbl[10] = '{4,  1,  1'b0, 1, 2, 1'b0, -1};  // partial again over old data

    for (int i = 0; i < FL; i++) known[i] = 1'b0;
    rst = 1'b1; start = 1'b0; load_valid = 1'b0;
    gemm_size = '0; cnn_size = '0; load_data = '0;
    tick; tick;
    chk("reset_outputs", CW'({load_ready, act_sig, data_out, frame_done, busy, cfg_err}), CW'(0));
    rst = 1'b0;
    tick;
    chk("idle_after_reset", CW'({load_ready, busy, cfg_err}), CW'(0));

    for (int i = 0; i < 11; i++) begin
      if (tbl[i].err) bad_cfg(tbl[i].g, tbl[i].cn);
      else run_tile(tbl[i].g, tbl[i].cn, tbl[i].mode, tbl[i].gap, tbl[i].sdd, tbl[i].rst_at);
    end

    for (int n = 0; n < 8; n++) begin
      int g, cn;
      g  = $urandom_range(1, 16);
      cn = $urandom_range(0, g - 1);
      run_tile(g, cn, 2, 2, 1'($urandom_range(0, 1)), -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
